// File: rtl/ball_motion.sv
// Ball position stage: once per frame tick, erase the ball, step it one pixel,
// redraw it, then pulse logic_go and hold x/y while the collision logic runs.
module ball_motion #(
  parameter int         FRAME_TICKS = 833333,
  parameter int         LOGIC_WAIT  = 12,
  parameter logic [9:0] X_START     = 10'd80,
  parameter logic [9:0] Y_START     = 10'd100,
  parameter logic [2:0] BALL_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR   = 3'b000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic [9:0] x_max,
  input  logic [9:0] y_max,
  input  logic [9:0] size,
  input  logic       x_du,
  input  logic       y_du,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       logic_go,
  output logic       plot,
  output logic [9:0] vga_x,
  output logic [9:0] vga_y,
  output logic [2:0] colour,
  output logic       busy
);

  localparam int TW = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int WW = (LOGIC_WAIT > 1) ? $clog2(LOGIC_WAIT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_TICKS - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'((LOGIC_WAIT > 0) ? LOGIC_WAIT - 1 : 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ERASE  = 3'd1;
  localparam logic [2:0] S_MOVE   = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_LOGIC  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;

  logic [2:0]    state;
  logic [TW-1:0] tick;
  logic [WW-1:0] wcnt;
  logic [9:0]    px, py;
  logic [9:0]    x_lim, y_lim, x_next, y_next;
  logic          scanning, scan_last;

  // Saturating step; comparing against the limit avoids any x+1 overflow.
  assign x_lim  = x_max - size;
  assign y_lim  = y_max - size;
  assign x_next = x_du ? ((x >= x_lim) ? x_lim : x + 10'd1) : ((x == 10'd0) ? 10'd0 : x - 10'd1);
  assign y_next = y_du ? ((y >= y_lim) ? y_lim : y + 10'd1) : ((y == 10'd0) ? 10'd0 : y - 10'd1);

  assign scanning  = (state == S_ERASE) || (state == S_DRAW);
  assign scan_last = (size == 10'd0) || ((px == size - 10'd1) && (py == size - 10'd1));

  // Outputs decode from state so an async reset clears them immediately.
  assign plot     = scanning && (size != 10'd0);
  assign vga_x    = plot ? x + px : 10'd0;
  assign vga_y    = plot ? y + py : 10'd0;
  assign colour   = (state == S_DRAW) ? BALL_COLOUR : BG_COLOUR;
  assign logic_go = (state == S_LOGIC);
  assign busy     = (state != S_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      tick  <= '0;
      wcnt  <= '0;
      px    <= '0;
      py    <= '0;
      x     <= X_START;
      y     <= Y_START;
    end else begin
      case (state)
        S_IDLE: begin
          if (!enable) begin
            tick <= '0;
          end else if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= S_ERASE;
          end else begin
            tick <= tick + TW'(1);
          end
        end
        S_ERASE, S_DRAW: begin
          if (scan_last) begin
            px    <= '0;
            py    <= '0;
            state <= (state == S_ERASE) ? S_MOVE : S_LOGIC;
          end else if (px == size - 10'd1) begin
            px <= '0;
            py <= py + 10'd1;
          end else begin
            px <= px + 10'd1;
          end
        end
        S_MOVE: begin
          x     <= x_next;
          y     <= y_next;
          state <= S_DRAW;
        end
        S_LOGIC: state <= S_SETTLE;
        S_SETTLE: begin
          if (wcnt == WAIT_LAST) begin
            wcnt  <= '0;
            state <= S_IDLE;
          end else begin
            wcnt <= wcnt + WW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: step table, wall walks, enable gating,
// async reset mid-draw and the size=0 step.
module tb_ball_motion;
  localparam int FT = 4;
  localparam int LW = 12;

  logic       clk = 1'b0;
  logic       resetn, enable, x_du, y_du;
  logic [9:0] x_max, y_max, size;
  logic [9:0] x, y, vga_x, vga_y;
  logic       logic_go, plot, busy;
  logic [2:0] colour;

  int errors = 0;
  int checks = 0;
  logic [9:0] cx, cy;

  typedef struct {
    logic       xdu, ydu;
    logic [9:0] sz, ex, ey;
  } vec_t;
  vec_t tbl[5];

  ball_motion #(.FRAME_TICKS(FT), .LOGIC_WAIT(LW), .X_START(10'd80), .Y_START(10'd100),
                .BALL_COLOUR(3'b111), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .x_max(x_max), .y_max(y_max),
    .size(size), .x_du(x_du), .y_du(y_du), .x(x), .y(y), .logic_go(logic_go),
    .plot(plot), .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] nxt(input logic [9:0] p, input logic du,
                                     input logic [9:0] mx, input logic [9:0] sz);
    logic [9:0] lim;
    lim = mx - sz;
    if (du) return (p >= lim) ? lim : p + 10'd1;
    return (p == 10'd0) ? 10'd0 : p - 10'd1;
  endfunction

  // One full step: pixel order/colour, logic_go placement, settle length, final x/y.
  task automatic run_step(input logic [9:0] ex, input logic [9:0] ey);
    int sz, pi, go_cnt, settle;
    bit seen, done, prev_plot;
    logic [9:0] px, py, bx, by;
    logic [2:0] bc;
    sz = int'(size);
    pi = 0; go_cnt = 0; settle = 0; seen = 0; done = 0; prev_plot = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (busy) seen = 1;
      if (plot) begin
        if (pi < sz * sz) begin
          bx = cx; by = cy; bc = 3'b000;
          px = 10'(pi % sz); py = 10'(pi / sz);
        end else begin
          bx = ex; by = ey; bc = 3'b111;
          px = 10'((pi - sz * sz) % sz); py = 10'((pi - sz * sz) / sz);
        end
        chk("pixel", {9'd0, vga_x, vga_y, colour}, {9'd0, bx + px, by + py, bc});
        pi++;
      end
      if (logic_go) begin
        go_cnt++;
        chk("go_after_draw", {pi, prev_plot | (sz == 0)}, {2 * sz * sz, 1'b1});
      end else if (go_cnt > 0 && busy) begin
        settle++;
      end
      prev_plot = plot;
      if (seen && !busy) done = 1;
    end
    chk("step_done", done, 1);
    chk("plot_count", pi, 2 * sz * sz);
    chk("go_count", go_cnt, 1);
    chk("settle_len", settle, LW);
    chk("pos", {x, y}, {ex, ey});
    cx = ex; cy = ey;
  endtask

  initial begin
    int n;
    bit got;
    int pc, gc, bc;
    tbl[0] = '{1'b1, 1'b1, 10'd2,  10'd81, 10'd101};
    tbl[1] = '{1'b0, 1'b1, 10'd2,  10'd80, 10'd102};
    tbl[2] = '{1'b0, 1'b0, 10'd3,  10'd79, 10'd101};
    tbl[3] = '{1'b1, 1'b0, 10'd0,  10'd80, 10'd100};
    tbl[4] = '{1'b1, 1'b1, 10'd4,  10'd81, 10'd101};

    resetn = 1'b0; enable = 1'b0; x_du = 1'b1; y_du = 1'b1;
    x_max = 10'd160; y_max = 10'd120; size = 10'd2;
    repeat (3) @(negedge clk);
    chk("reset_pos", {x, y}, {10'd80, 10'd100});
    chk("reset_out", {logic_go, plot, busy, vga_x, vga_y, colour}, 26'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, plot, logic_go}, 3'b000);
    cx = 10'd80; cy = 10'd100;
    enable = 1'b1;

    foreach (tbl[i]) begin
      x_du = tbl[i].xdu; y_du = tbl[i].ydu; size = tbl[i].sz;
      run_step(tbl[i].ex, tbl[i].ey);
    end

    // Walk to the left wall, then one more step against it.
    size = 10'd4; x_du = 1'b0; y_du = 1'b0;
    for (int i = 0; i < 81; i++) run_step(nxt(cx, 1'b0, x_max, size), nxt(cy, 1'b0, y_max, size));
    chk("at_left", {x, y}, {10'd0, 10'd20});
    run_step(10'd0, 10'd19);

    // Walk to right/bottom saturation, then one more step against it.
    x_du = 1'b1; y_du = 1'b1;
    for (int i = 0; i < 156; i++) run_step(nxt(cx, 1'b1, x_max, size), nxt(cy, 1'b1, y_max, size));
    chk("at_right", {x, y}, {10'd156, 10'd116});
    run_step(10'd156, 10'd116);

    // Enable low: nothing moves; then first plot exactly FT cycles after raising.
    enable = 1'b0;
    pc = 0; gc = 0; bc = 0;
    repeat (100) begin
      @(negedge clk);
      pc += int'(plot); gc += int'(logic_go); bc += int'(busy);
    end
    chk("en_low_plot", pc, 0);
    chk("en_low_go", gc, 0);
    chk("en_low_busy", bc, 0);
    enable = 1'b1;
    n = 0; got = 0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      n++;
      if (plot) got = 1;
    end
    chk("first_plot_delay", n, FT);

    // Reset asserted during draw: outputs clear without a clock edge.
    got = 0;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (plot && colour == 3'b111) got = 1;
    end
    chk("reached_draw", got, 1);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pos", {x, y}, {10'd80, 10'd100});
    chk("async_rst_out", {logic_go, plot, busy, vga_x, vga_y, colour}, 26'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {busy, x}, {1'b0, 10'd80});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
